fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall_id  input  1  decode stall (load-use); IF/ID must hold.
REQ-005 redirect_valid  input  1  branch/jump taken; flush and redirect.
REQ-006 redirect_pc  input  32  redirect target.
REQ-007 imem_req  output  1  instruction memory request, always accepted in the issuing cycle.
REQ-008 imem_addr  output  32  word address of the request.
REQ-009 imem_rvalid  input  1  response valid, 1 or more cycles after the request.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 if_id_valid  output  1  IF/ID register holds a live instruction.
REQ-012 if_id_instr  output  32  IF/ID instruction.
REQ-013 if_id_pc_plus4  output  32  IF/ID PC+4.
REQ-014 pc_out  output  32  current fetch PC.

Function
REQ-015 The FSM SHALL have states FETCH (issue request), WAIT (one request outstanding) and HOLD (skid buffer full).
REQ-016 FETCH: imem_req=1, imem_addr=pc; next state WAIT.
REQ-017 WAIT without rvalid: imem_req=0; stay in WAIT.
REQ-018 WAIT with rvalid and IF/ID free (stall_id=0): load IF/ID with {1, rdata, pc+4}, pc<=pc+4, issue next request in the same cycle at pc+4, stay in WAIT; with 1-cycle memory this gives one instruction per cycle.
REQ-019 WAIT with rvalid and stall_id=1: capture rdata into the skid buffer, pc<=pc+4, no new request, go to HOLD.
REQ-020 HOLD: imem_req=0; when stall_id=0, move skid into IF/ID, clear skid, go to FETCH.
REQ-021 While stall_id=1 with no new data accepted, IF/ID SHALL hold its value, with no loss or duplication of instructions.
REQ-022 redirect_valid SHALL take priority over stall_id and rvalid: pc<=redirect_pc, if_id_valid<=0, skid cleared, next state FETCH.
REQ-023 A redirect in WAIT with no rvalid in that cycle SHALL set a drop flag; the next rvalid is discarded, and the flag clears on that rvalid.
REQ-024 A redirect in the same cycle as rvalid SHALL discard that response.
REQ-025 imem_rvalid SHALL be ignored in FETCH and HOLD.
REQ-026 PC arithmetic SHALL be 32-bit modulo; pc+4 from 32'hFFFF_FFFC wraps to 0.
REQ-027 pc_out SHALL equal the internal pc register.

Reset
REQ-028 While rst_n=0, all outputs SHALL clear immediately: pc=RESET_PC, if_id_valid=0, if_id_instr=32'h0 (NOP), if_id_pc_plus4=0, imem_req=0, skid and drop flag cleared.
REQ-029 The state SHALL be FETCH after reset; the first request at RESET_PC issues in the first clock edge cycle after rst_n rises.
REQ-030 Reset asserted mid-WAIT SHALL abandon the outstanding request, and a late rvalid SHALL be ignored per REQ-025.

Structure
REQ-031 The shared package pipeline_pkg SHALL hold the default RESET_PC, NOP_INSTR (32'h0) and the fetch FSM state enum.
REQ-032 The skid buffer (valid, instr, pc_plus4) MAY be the sub-module if_skid_buf; everything else is flat.

Verification
REQ-033 Release reset, 1-cycle memory -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; IF/ID pc_plus4 0x4, 0x8, 0xC one per cycle.
REQ-034 stall_id high 3 cycles mid-stream -> IF/ID frozen, skid holds next instruction, imem_req low; on release, the sequence continues with no gap, loss or duplicate.
REQ-035 redirect_pc=0x40 while a request is pending (3-cycle memory) -> late response dropped, if_id_valid=0, next imem_addr=0x40.
REQ-036 redirect_valid and stall_id both high -> redirect wins: IF/ID flushed, pc=redirect_pc.
REQ-037 3-cycle memory latency -> exactly one outstanding request; imem_req pulses every 3 cycles.
REQ-038 rst_n low during WAIT, then rvalid after release -> outputs cleared asynchronously, stray rvalid ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: reset PC, the NOP encoding and the fetch FSM states.
package pipeline_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer that parks a fetched instruction while decode is stalled.
module if_skid_buf
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] wr_instr,
    input  logic [31:0] wr_pc_plus4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'h0;
        end else if (clear) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'h0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= wr_instr;
            pc_plus4 <= wr_pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requests, IF/ID register and skid buffer.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_FETCH | issue a request at pc
// S_WAIT  | one request outstanding at pc; response may chain a new one
// S_HOLD  | skid buffer full, waiting for decode to release the stall
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_id,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] pc_out
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc, pc_nxt, pc_plus4;
    logic         drop, drop_nxt;
    logic         req;
    logic         id_load_mem, id_load_skid, id_flush, id_bubble;
    logic         skid_load, skid_clear, skid_valid;
    logic [31:0]  skid_instr, skid_pc_plus4;

    assign pc_plus4 = pc_inc(pc);
    assign pc_out   = pc;
    // The FSM resets into S_FETCH, so the request must be masked while reset is held.
    assign imem_req = req & rst_n;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        drop_nxt     = drop & ~imem_rvalid;
        req          = 1'b0;
        imem_addr    = pc;
        id_load_mem  = 1'b0;
        id_load_skid = 1'b0;
        id_flush     = 1'b0;
        id_bubble    = 1'b0;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;

        if (redirect_valid) begin
            pc_nxt     = redirect_pc;
            id_flush   = 1'b1;
            skid_clear = 1'b1;
            state_nxt  = S_FETCH;
            // A response still in flight after this cycle belongs to the old path.
            if (state == S_WAIT)
                drop_nxt = drop | ~imem_rvalid;
        end else begin
            case (state)
                S_FETCH: begin
                    req       = 1'b1;
                    state_nxt = S_WAIT;
                    id_bubble = ~stall_id;
                end
                S_WAIT: begin
                    if (imem_rvalid && !drop) begin
                        pc_nxt = pc_plus4;
                        if (!stall_id) begin
                            id_load_mem = 1'b1;
                            req         = 1'b1;
                            imem_addr   = pc_plus4;
                        end else begin
                            skid_load = 1'b1;
                            state_nxt = S_HOLD;
                        end
                    end else begin
                        id_bubble = ~stall_id;
                    end
                end
                S_HOLD: begin
                    if (!stall_id) begin
                        id_load_skid = 1'b1;
                        skid_clear   = 1'b1;
                        state_nxt    = S_FETCH;
                    end
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            drop  <= drop_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid    <= 1'b0;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'h0;
        end else if (id_flush) begin
            if_id_valid <= 1'b0;
        end else if (id_load_mem) begin
            if_id_valid    <= 1'b1;
            if_id_instr    <= imem_rdata;
            if_id_pc_plus4 <= pc_plus4;
        end else if (id_load_skid) begin
            if_id_valid    <= skid_valid;
            if_id_instr    <= skid_instr;
            if_id_pc_plus4 <= skid_pc_plus4;
        end else if (id_bubble) begin
            if_id_valid <= 1'b0;
        end
    end

    if_skid_buf u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (skid_load),
        .clear       (skid_clear),
        .wr_instr    (imem_rdata),
        .wr_pc_plus4 (pc_plus4),
        .valid       (skid_valid),
        .instr       (skid_instr),
        .pc_plus4    (skid_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a fixed-latency in-order instruction memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_id = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] pc_out;

    int checks = 0;
    int errors = 0;

    int          lat = 1;
    int          cyc = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_id       (stall_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .pc_out         (pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory: a request seen in cycle c is answered in cycle c+lat.
    always @(posedge clk) begin
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
    end

    always @(negedge clk) begin
        if (imem_req === 1'b1) begin
            q_addr.push_back(imem_addr);
            q_due.push_back(cyc + lat);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic apply_reset(input int l);
        next_cycle();
        rst_n = 1'b0; stall_id = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        lat = l;
        q_addr.delete();
        q_due.delete();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) next_cycle();
        mid();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", if_id_valid); end
        checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", if_id_instr); end
        checks++; if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h want 0", if_id_pc_plus4); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pc_out); end
        next_cycle();
        rst_n = 1'b1;
        mid();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got %b/%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            mid();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*i)) begin errors++; $display("FAIL stream_addr[%0d] got %b/%h want 1/%h", i, imem_req, imem_addr, 32'(4*i)); end
            checks++; if (pc_out !== 32'(4*(i-1))) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, pc_out, 32'(4*(i-1))); end
            if (i >= 2) begin
                checks++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'(4*(i-1)) || if_id_instr !== instr_of(32'(4*(i-2))))
                    begin errors++; $display("FAIL stream_ifid[%0d] got %b/%h/%h want 1/%h/%h", i, if_id_valid, if_id_pc_plus4, if_id_instr, 32'(4*(i-1)), instr_of(32'(4*(i-2)))); end
            end else begin
                checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL stream_ifid[%0d] valid got %b want 0", i, if_id_valid); end
            end
        end
    endtask

    task automatic test_stall();
        next_cycle();
        stall_id = 1'b1;
        mid();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req0 got %b want 0", imem_req); end
        checks++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h10) begin errors++; $display("FAIL stall_ifid0 got %b/%h want 1/10", if_id_valid, if_id_pc_plus4); end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            mid();
            checks++; if (imem_req !== 1'b0 || if_id_pc_plus4 !== 32'h10 || if_id_instr !== instr_of(32'hC) || pc_out !== 32'h14)
                begin errors++; $display("FAIL stall_hold[%0d] got req %b pc4 %h instr %h pc %h want 0/10/%h/14", i, imem_req, if_id_pc_plus4, if_id_instr, instr_of(32'hC), pc_out); end
        end
        next_cycle();
        stall_id = 1'b0;
        mid();
        checks++; if (imem_req !== 1'b0 || if_id_pc_plus4 !== 32'h10) begin errors++; $display("FAIL stall_rel got %b/%h want 0/10", imem_req, if_id_pc_plus4); end
        next_cycle();
        mid();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h14 || if_id_instr !== instr_of(32'h10))
            begin errors++; $display("FAIL stall_skid got %b/%h/%h want 1/14/%h", if_id_valid, if_id_pc_plus4, if_id_instr, instr_of(32'h10)); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin errors++; $display("FAIL stall_refetch got %b/%h want 1/14", imem_req, imem_addr); end
        next_cycle();
        mid();
        checks++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h18) begin errors++; $display("FAIL stall_bubble got %b/%h want 0/18", if_id_valid, imem_addr); end
        next_cycle();
        mid();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h18 || if_id_instr !== instr_of(32'h14))
            begin errors++; $display("FAIL stall_resume got %b/%h/%h want 1/18/%h", if_id_valid, if_id_pc_plus4, if_id_instr, instr_of(32'h14)); end
    endtask

    task automatic test_redirect_pending();
        apply_reset(3);
        mid();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL redir_c0 got %b/%h want 1/0", imem_req, imem_addr); end
        next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        mid();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_c1 req got %b want 0", imem_req); end
        next_cycle();
        redirect_valid = 1'b0;
        mid();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || if_id_valid !== 1'b0 || pc_out !== 32'h40)
            begin errors++; $display("FAIL redir_c2 got req %b addr %h valid %b pc %h want 1/40/0/40", imem_req, imem_addr, if_id_valid, pc_out); end
        next_cycle();
        mid();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_drop_req got %b want 0", imem_req); end
        next_cycle();
        mid();
        checks++; if (if_id_valid !== 1'b0 || pc_out !== 32'h40) begin errors++; $display("FAIL redir_dropped got %b/%h want 0/40", if_id_valid, pc_out); end
        next_cycle();
        mid();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin errors++; $display("FAIL redir_next got %b/%h want 1/44", imem_req, imem_addr); end
        next_cycle();
        mid();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h44 || if_id_instr !== instr_of(32'h40))
            begin errors++; $display("FAIL redir_ifid got %b/%h/%h want 1/44/%h", if_id_valid, if_id_pc_plus4, if_id_instr, instr_of(32'h40)); end
    endtask

    task automatic test_redirect_same_cycle();
        next_cycle();
        mid();
        next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        mid();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_rv_req got %b want 0", imem_req); end
        next_cycle();
        redirect_valid = 1'b0;
        mid();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80 || if_id_valid !== 1'b0)
            begin errors++; $display("FAIL redir_rv_fetch got %b/%h/%b want 1/80/0", imem_req, imem_addr, if_id_valid); end
        repeat (3) next_cycle();
        mid();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h84) begin errors++; $display("FAIL redir_rv_nodrop got %b/%h want 1/84", imem_req, imem_addr); end
        next_cycle();
        mid();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h84 || if_id_instr !== instr_of(32'h80))
            begin errors++; $display("FAIL redir_rv_ifid got %b/%h/%h want 1/84/%h", if_id_valid, if_id_pc_plus4, if_id_instr, instr_of(32'h80)); end
    endtask

    task automatic test_latency3();
        apply_reset(3);
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) next_cycle();
            mid();
            checks++; if (imem_req !== (i % 3 == 0)) begin errors++; $display("FAIL lat3_req[%0d] got %b want %b", i, imem_req, (i % 3 == 0)); end
            if (i % 3 == 0) begin
                checks++; if (imem_addr !== 32'(4*(i/3))) begin errors++; $display("FAIL lat3_addr[%0d] got %h want %h", i, imem_addr, 32'(4*(i/3))); end
            end
        end
        next_cycle();
        mid();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h8) begin errors++; $display("FAIL lat3_ifid got %b/%h want 1/8", if_id_valid, if_id_pc_plus4); end
    endtask

    task automatic test_redirect_stall();
        apply_reset(1);
        next_cycle();
        next_cycle();
        stall_id = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        mid();
        checks++; if (imem_req !== 1'b0 || if_id_pc_plus4 !== 32'h4) begin errors++; $display("FAIL rs_c2 got %b/%h want 0/4", imem_req, if_id_pc_plus4); end
        next_cycle();
        redirect_valid = 1'b0;
        mid();
        checks++; if (if_id_valid !== 1'b0 || pc_out !== 32'h100 || imem_req !== 1'b1 || imem_addr !== 32'h100)
            begin errors++; $display("FAIL rs_flush got valid %b pc %h req %b addr %h want 0/100/1/100", if_id_valid, pc_out, imem_req, imem_addr); end
        next_cycle();
        stall_id = 1'b0;
        mid();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL rs_next got %b/%h want 1/104", imem_req, imem_addr); end
        next_cycle();
        mid();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h104 || if_id_instr !== instr_of(32'h100))
            begin errors++; $display("FAIL rs_ifid got %b/%h/%h want 1/104/%h", if_id_valid, if_id_pc_plus4, if_id_instr, instr_of(32'h100)); end
    endtask

    task automatic test_wrap();
        apply_reset(1);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        mid();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_c0 req got %b want 0", imem_req); end
        next_cycle();
        redirect_valid = 1'b0;
        mid();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_c1 got %b/%h want 1/fffffffc", imem_req, imem_addr); end
        next_cycle();
        mid();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_c2 got %b/%h want 1/0", imem_req, imem_addr); end
        next_cycle();
        mid();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h0 || if_id_instr !== instr_of(32'hFFFF_FFFC) || pc_out !== 32'h0)
            begin errors++; $display("FAIL wrap_ifid got %b/%h/%h pc %h want 1/0/%h/0", if_id_valid, if_id_pc_plus4, if_id_instr, pc_out, instr_of(32'hFFFF_FFFC)); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset(3);
        repeat (4) next_cycle();
        mid();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h4 || pc_out !== 32'h4)
            begin errors++; $display("FAIL rmw_pre got %b/%h pc %h want 1/4/4", if_id_valid, if_id_pc_plus4, pc_out); end
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h0 || pc_out !== 32'h0)
            begin errors++; $display("FAIL rmw_async got req %b valid %b instr %h pc4 %h pc %h want all 0", imem_req, if_id_valid, if_id_instr, if_id_pc_plus4, pc_out); end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        mid();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rmw_restart got %b/%h want 1/0", imem_req, imem_addr); end
        next_cycle();
        mid();
        checks++; if (if_id_valid !== 1'b0 || pc_out !== 32'h0 || imem_req !== 1'b0)
            begin errors++; $display("FAIL rmw_stray got valid %b pc %h req %b want 0/0/0", if_id_valid, pc_out, imem_req); end
        next_cycle();
        next_cycle();
        mid();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL rmw_resp got %b/%h want 1/4", imem_req, imem_addr); end
        next_cycle();
        mid();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h4 || if_id_instr !== instr_of(32'h0))
            begin errors++; $display("FAIL rmw_ifid got %b/%h/%h want 1/4/%h", if_id_valid, if_id_pc_plus4, if_id_instr, instr_of(32'h0)); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_pending();
        test_redirect_same_cycle();
        test_latency3();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
